// File: rtl/aes_pkg.sv
// Shared AES-128 inverse-cipher types and GF(2^8) helpers.
// Provides state/key-schedule types, InvSubBytes and key selection.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] state_t;
    typedef logic [128*(NUM_ROUNDS+1)-1:0] key_sched_t;

    function automatic logic [7:0] xtime(
        input logic [7:0] a
    );
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero.
    function automatic logic [7:0] gf_inv(
        input logic [7:0] a
    );
        logic [7:0] sq;
        logic [7:0] r;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(
        input logic [7:0] b
    );
        logic [7:0] x;
        x = {b[6:0], b[7]}
          ^ {b[4:0], b[7:5]}
          ^ {b[1:0], b[7:2]}
          ^ 8'h05;
        return gf_inv(x);
    endfunction

    // Step s uses round key 10-s.
    function automatic state_t round_key_sel(
        input key_sched_t keys,
        input logic [3:0] step
    );
        int idx;
        idx = NUM_ROUNDS - int'(step);
        return keys[128*idx +: 128];
    endfunction

endpackage

// File: rtl/inv_round_unit.sv
// One inverse-cipher step: ARK, optional InvMixColumns, InvShiftRows,
// InvSubBytes. Ports: state, key, skip_mc in; next_state out.
module inv_round_unit
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t key,
    input  logic   skip_mc,
    output state_t next_state
);

    function automatic state_t inv_mix_columns(
        input state_t s
    );
        state_t r;
        logic [7:0] a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h0e)
                             ^ gf_mul(a1, 8'h0b)
                             ^ gf_mul(a2, 8'h0d)
                             ^ gf_mul(a3, 8'h09);
            r[119-32*c -: 8] = gf_mul(a0, 8'h09)
                             ^ gf_mul(a1, 8'h0e)
                             ^ gf_mul(a2, 8'h0b)
                             ^ gf_mul(a3, 8'h0d);
            r[111-32*c -: 8] = gf_mul(a0, 8'h0d)
                             ^ gf_mul(a1, 8'h09)
                             ^ gf_mul(a2, 8'h0e)
                             ^ gf_mul(a3, 8'h0b);
            r[103-32*c -: 8] = gf_mul(a0, 8'h0b)
                             ^ gf_mul(a1, 8'h0d)
                             ^ gf_mul(a2, 8'h09)
                             ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    // Row r rotates right by r columns.
    function automatic state_t inv_shift_rows(
        input state_t s
    );
        state_t r;
        int src;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                src = 4 * ((c + 4 - w) % 4) + w;
                r[127-8*(4*c+w) -: 8] = s[127-8*src -: 8];
            end
        end
        return r;
    endfunction

    function automatic state_t inv_sub_bytes(
        input state_t s
    );
        state_t r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return r;
    endfunction

    state_t ark;
    state_t mc;

    assign ark = state ^ key;
    assign mc  = skip_mc ? ark : inv_mix_columns(ark);
    assign next_state = inv_sub_bytes(inv_shift_rows(mc));

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryptor, UNROLL steps per clock, optional CBC.
// Ports: clk, rst_n, round_keys, in_*/out_* handshakes, iv, iv_load.
module aes128_decrypt_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter bit CBC_EN = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1407:0] round_keys,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    input  logic          iv_load,
    input  logic [127:0]  iv,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data
);

    localparam logic [3:0] STEP = 4'(UNROLL);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    fsm_t       fsm_q;
    fsm_t       fsm_d;
    logic       in_ready_q;
    logic       out_valid_q;
    state_t     st_q;
    state_t     out_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_nxt;
    logic       accept;
    logic       last_step;
    logic       release_out;
    state_t     chain;
    state_t     final_pt;
    state_t     stage [UNROLL+1];

    assign accept      = in_ready_q & in_valid;
    assign cnt_nxt     = cnt_q + STEP;
    assign last_step   = (fsm_q == RUN) && (cnt_nxt == LAST);
    assign release_out = (fsm_q == DONE) && out_ready;

    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            IDLE: if (accept) fsm_d = RUN;
            RUN: if (cnt_nxt == LAST) fsm_d = DONE;
            DONE: if (out_ready) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    // in_ready is a flop so it holds 0 through reset and
    // has no path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            in_ready_q <= (fsm_d == IDLE);
        end
    end

    assign stage[0] = st_q;

    for (genvar j = 0; j < UNROLL; j++) begin : g_round
        localparam logic [3:0] J = 4'(j);
        logic [3:0] s;
        assign s = cnt_q + J;
        inv_round_unit u_round (
            .state      (stage[j]),
            .key        (round_key_sel(round_keys, s)),
            .skip_mc    (s == 4'd0),
            .next_state (stage[j+1])
        );
    end

    assign final_pt = stage[UNROLL] ^ round_keys[127:0] ^ chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                st_q  <= in_data;
                cnt_q <= '0;
            end
            if (fsm_q == RUN) begin
                st_q  <= stage[UNROLL];
                cnt_q <= cnt_nxt;
            end
            if (last_step) begin
                out_q       <= final_pt;
                out_valid_q <= 1'b1;
            end
            if (release_out) out_valid_q <= 1'b0;
        end
    end

    if (CBC_EN) begin : g_cbc
        state_t chain_q;
        state_t ct_hold_q;
        // An IV loaded on the accept edge lands before this
        // block's final XOR, so it chains the same block.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain_q   <= '0;
                ct_hold_q <= '0;
            end else begin
                if ((fsm_q == IDLE) && iv_load) chain_q <= iv;
                if (accept) ct_hold_q <= in_data;
                if (release_out) chain_q <= ct_hold_q;
            end
        end
        assign chain = chain_q;
    end else begin : g_no_cbc
        logic unused_cbc;
        assign unused_cbc = ^{iv, iv_load};
        assign chain = '0;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Self-checking bench: five DUT configurations vs a byte-matrix AES model.
// Ports: none (drives clk, rst_n and all handshakes internally).
module tb_aes128_decrypt_iter;

    localparam int ND = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1407:0] round_keys = '0;
    logic          in_valid = 1'b0;
    logic          iv_load = 1'b0;
    logic          out_ready = 1'b0;
    logic [127:0]  in_data = '0;
    logic [127:0]  iv = '0;
    logic          ir [ND];
    logic          ov [ND];
    logic [127:0]  od [ND];

    always #5 clk = ~clk;

    aes128_decrypt_iter #(.UNROLL(1), .CBC_EN(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .round_keys(round_keys),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .iv_load(iv_load), .iv(iv), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]));
    aes128_decrypt_iter #(.UNROLL(2), .CBC_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .round_keys(round_keys),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .iv_load(iv_load), .iv(iv), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]));
    aes128_decrypt_iter #(.UNROLL(5), .CBC_EN(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .round_keys(round_keys),
        .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .iv_load(iv_load), .iv(iv), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]));
    aes128_decrypt_iter #(.UNROLL(10), .CBC_EN(1'b0)) u3 (
        .clk(clk), .rst_n(rst_n), .round_keys(round_keys),
        .in_valid(in_valid), .in_ready(ir[3]), .in_data(in_data),
        .iv_load(iv_load), .iv(iv), .out_valid(ov[3]),
        .out_ready(out_ready), .out_data(od[3]));
    aes128_decrypt_iter #(.UNROLL(1), .CBC_EN(1'b1)) u4 (
        .clk(clk), .rst_n(rst_n), .round_keys(round_keys),
        .in_valid(in_valid), .in_ready(ir[4]), .in_data(in_data),
        .iv_load(iv_load), .iv(iv), .out_valid(ov[4]),
        .out_ready(out_ready), .out_data(od[4]));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_q [ND][$];
    int rise_q [ND][$];
    logic [127:0] out_q [ND][$];
    logic ovp [ND];
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [127:0] chain_m = '0;

    function automatic int n_of(input int i);
        case (i)
            0: return 10;
            1: return 5;
            2: return 2;
            3: return 1;
            default: return 10;
        endcase
    endfunction

    function automatic logic [7:0] ref_xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] ref_mul(
        input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = ref_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(
        input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox;
        logic [7:0] inv, a8;
        for (int a = 0; a < 256; a++) begin
            a8 = 8'(a);
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (ref_mul(a8, 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2)
                  ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) isb[sb[a]] = 8'(a);
    endtask

    function automatic logic [1407:0] key_expand(
        input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        logic [1407:0] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]],
                     sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = ref_xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [7:0] coef(input int d);
        case (d)
            0: return 8'h0e;
            1: return 8'h0b;
            2: return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    // Textbook ordering: ISR, ISB, ARK(k_r), IMC; on a row/col matrix.
    function automatic logic [127:0] ref_decrypt(
        input logic [1407:0] ks, input logic [127:0] ct);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] col [4];
        logic [7:0] acc;
        logic [127:0] k, pt;
        k = ks[1280 +: 128];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = ct[127-8*(4*c+r) -: 8]
                        ^ k[127-8*(4*c+r) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = isb[s[r][(c-r+4)%4]];
            k = ks[128*rnd +: 128];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r][c] = t[r][c] ^ k[127-8*(4*c+r) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) col[r] = s[r][c];
                    for (int r = 0; r < 4; r++) begin
                        acc = 0;
                        for (int j = 0; j < 4; j++)
                            acc ^= ref_mul(coef((j-r+4)%4), col[j]);
                        s[r][c] = acc;
                    end
                end
            end
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                pt[127-8*(4*c+r) -: 8] = s[r][c];
        return pt;
    endfunction

    task automatic chk(input string tag,
        input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag,
        input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        logic pre [ND];
        for (int i = 0; i < ND; i++) pre[i] = ir[i] & in_valid;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < ND; i++) begin
            if (pre[i]) acc_q[i].push_back(cyc);
            if (ov[i] && !ovp[i]) begin
                rise_q[i].push_back(cyc);
                out_q[i].push_back(od[i]);
            end
            ovp[i] = ov[i];
        end
    endtask

    task automatic clear_q;
        for (int i = 0; i < ND; i++) begin
            acc_q[i].delete();
            rise_q[i].delete();
            out_q[i].delete();
        end
    endtask

    function automatic logic all_done();
        logic d;
        d = 1'b1;
        for (int i = 0; i < ND; i++)
            if (rise_q[i].size() == 0 || !ir[i]) d = 1'b0;
        return d;
    endfunction

    task automatic check_results(input string tag,
        input logic [127:0] dec, output logic [127:0] cbc_out);
        logic [127:0] e;
        cbc_out = '0;
        for (int i = 0; i < ND; i++) begin
            if (rise_q[i].size() > 0 && acc_q[i].size() > 0) begin
                e = (i == 4) ? (dec ^ chain_m) : dec;
                chk($sformatf("%s_data_%0d", tag, i), out_q[i][0], e);
                chki($sformatf("%s_lat_%0d", tag, i),
                     rise_q[i][0] - acc_q[i][0], n_of(i));
                if (i == 4) cbc_out = out_q[i][0];
            end
        end
    endtask

    task automatic run_block(input string tag,
        input logic [127:0] ct, input logic ld,
        input logic [127:0] ivv, output logic [127:0] cbc_out);
        logic [127:0] dec;
        dec = ref_decrypt(round_keys, ct);
        clear_q();
        in_data = ct;
        iv = ivv;
        iv_load = ld;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        iv_load = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        if (ld) chain_m = ivv;
        for (int k = 0; k < 30 && !all_done(); k++) tick();
        chkb({tag, "_done"}, all_done(), 1'b1);
        check_results(tag, dec, cbc_out);
        chain_m = ct;
    endtask

    logic [127:0] ct_c1, pt_c1, ct_b, pt_b, dec, cbo, ctr;
    int nacc;

    initial begin
        for (int i = 0; i < ND; i++) ovp[i] = 1'b0;
        build_sbox();
        ct_c1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt_c1 = 128'h00112233445566778899aabbccddeeff;
        ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
        pt_b  = 128'h3243f6a8885a308d313198a2e0370734;

        // reset state
        repeat (3) tick();
        for (int i = 0; i < ND; i++) begin
            chkb($sformatf("rst_in_ready_%0d", i), ir[i], 1'b0);
            chkb($sformatf("rst_out_valid_%0d", i), ov[i], 1'b0);
            chk($sformatf("rst_out_data_%0d", i), od[i], '0);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < ND; i++)
            chkb($sformatf("post_rst_ready_%0d", i), ir[i], 1'b1);

        // FIPS-197 C.1 across all unroll factors
        round_keys = key_expand(128'h000102030405060708090a0b0c0d0e0f);
        chk("c1_k10", round_keys[1280 +: 128],
            128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("c1_model", ref_decrypt(round_keys, ct_c1), pt_c1);
        run_block("c1", ct_c1, 1'b0, '0, cbo);

        // Appendix B with downstream back-pressure
        round_keys = key_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        dec = ref_decrypt(round_keys, ct_b);
        chk("b_model", dec, pt_b);
        clear_q();
        in_data = ct_b;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        for (int h = 0; h < 5; h++) begin
            for (int i = 0; i < ND; i++) begin
                chkb($sformatf("b_hold_ov_%0d_%0d", h, i), ov[i], 1'b1);
                chkb($sformatf("b_hold_ir_%0d_%0d", h, i), ir[i], 1'b0);
                chk($sformatf("b_hold_od_%0d_%0d", h, i), od[i],
                    (i == 4) ? (dec ^ chain_m) : dec);
            end
            tick();
        end
        check_results("b", dec, cbo);
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < ND; i++)
            chkb($sformatf("b_release_ov_%0d", i), ov[i], 1'b0);
        tick();
        for (int i = 0; i < ND; i++)
            chkb($sformatf("b_release_ir_%0d", i), ir[i], 1'b1);
        chain_m = ct_b;

        // SP800-38A CBC, IV loaded with the first block
        run_block("cbc1", 128'h7649abac8119b246cee98e9b12e9197d,
                  1'b1, 128'h000102030405060708090a0b0c0d0e0f, cbo);
        chk("cbc_pt1", cbo, 128'h6bc1bee22e409f96e93d7e117393172a);
        run_block("cbc2", 128'h5086cb9b507219ee95db113a917678b2,
                  1'b0, '0, cbo);
        chk("cbc_pt2", cbo, 128'hae2d8a571e03ac9c9eb76fac45af8e51);

        // random keys, ciphertexts and IV loads
        for (int n = 0; n < 6; n++) begin
            round_keys = key_expand({$urandom, $urandom,
                                     $urandom, $urandom});
            run_block($sformatf("rnd%0d", n),
                      {$urandom, $urandom, $urandom, $urandom},
                      1'($urandom_range(1)),
                      {$urandom, $urandom, $urandom, $urandom}, cbo);
        end

        // reset during RUN aborts the block and clears the chain
        round_keys = key_expand(128'h000102030405060708090a0b0c0d0e0f);
        clear_q();
        in_data = ct_c1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < ND; i++)
            chkb($sformatf("mid_rst_ov_%0d", i), ov[i], 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < ND; i++)
            chkb($sformatf("mid_rst_ready_%0d", i), ir[i], 1'b1);
        chki("mid_rst_no_out_0", rise_q[0].size(), 0);
        chki("mid_rst_no_out_4", rise_q[4].size(), 0);
        chain_m = '0;
        run_block("after_rst", ct_c1, 1'b0, '0, cbo);
        chk("after_rst_cbc", cbo, pt_c1);

        // back-to-back with in_valid held high
        ctr = {$urandom, $urandom, $urandom, $urandom};
        dec = ref_decrypt(round_keys, ctr);
        clear_q();
        in_data = ctr;
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (40) tick();
        in_valid = 1'b0;
        repeat (15) tick();
        for (int i = 0; i < ND; i++) begin
            nacc = (40 + n_of(i) + 1) / (n_of(i) + 2);
            chki($sformatf("b2b_accepts_%0d", i), acc_q[i].size(), nacc);
            chki($sformatf("b2b_outputs_%0d", i),
                 out_q[i].size(), acc_q[i].size());
            for (int k = 1; k < acc_q[i].size(); k++)
                chki($sformatf("b2b_gap_%0d_%0d", i, k),
                     acc_q[i][k] - acc_q[i][k-1], n_of(i) + 2);
            for (int k = 0; k < out_q[i].size(); k++)
                chk($sformatf("b2b_data_%0d_%0d", i, k), out_q[i][k],
                    (i != 4) ? dec : (k == 0) ? (dec ^ chain_m)
                                              : (dec ^ ctr));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
